// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation encoding.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: 4:1 next-state mux feeding a flop
// with async reset, synchronous clear and enable.
module usr_bit_cell
    import shift_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  mode_t sel,
    input  logic  from_left,   // bit above (i+1), taken on SHR
    input  logic  from_right,  // bit below (i-1), taken on SHL
    input  logic  pin_bit,
    output logic  q
);

    logic d;

    always_comb begin
        d = q;
        case (sel)
            MODE_HOLD: d = q;
            MODE_SHR:  d = from_left;
            MODE_SHL:  d = from_right;
            MODE_LOAD: d = pin_bit;
            default:   d = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (clr) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// optional rotate, with a saturating count of shifts since the last load/clear.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic                       rotate,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           pin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int unsigned       CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(WIDTH);

    mode_t op;
    logic  msb_in;
    logic  lsb_in;

    assign op     = mode_t'(mode);
    assign msb_in = rotate ? q[0]       : sin_r;
    assign lsb_in = rotate ? q[WIDTH-1] : sin_l;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_left;
        logic from_right;

        if (i == WIDTH - 1) begin : g_top
            assign from_left = msb_in;
        end else begin : g_inner_l
            assign from_left = q[i+1];
        end

        if (i == 0) begin : g_bottom
            assign from_right = lsb_in;
        end else begin : g_inner_r
            assign from_right = q[i-1];
        end

        usr_bit_cell #(
            .RESET_BIT (RESET_VAL[i])
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .en         (en),
            .sel        (op),
            .from_left  (from_left),
            .from_right (from_right),
            .pin_bit    (pin[i]),
            .q          (q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_cnt <= '0;
        end else if (clr) begin
            shift_cnt <= '0;
        end else if (en) begin
            if (op == MODE_LOAD) begin
                shift_cnt <= '0;
            end else if (is_shift(op) && (shift_cnt != CNT_MAX)) begin
                shift_cnt <= shift_cnt + CW'(1);
            end
        end
    end

    assign done   = (shift_cnt == CNT_MAX);
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule
